bmp_stream_writer: RTL and testbench
====================================

Name: bmp_stream_writer

Overview:
Synthesizable successor to the simulation-only BMP dump block. Converts a raster-order RGB/gray pixel stream into a complete BMP file byte stream on a valid/ready byte port. The 14+40-byte header, the optional 256-entry gray palette and the 4-byte row padding are all generated in hardware, so the byte stream can feed a UART, DMA or file-capture bench with no frame buffer. Rows are emitted top-down; the header encodes a negative biHeight, so the first input row is the first stored row.

Parameters:
WIDTH, 256, pixels per row (1..4095)
HEIGHT, 256, rows per frame (1..4095)
CHANNELS, 3, 3 = 24-bit BGR; 1 = 8-bit gray with palette
PPM, 2835, pixels-per-metre written to biXPelsPerMeter and biYPelsPerMeter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  pulse; begins one frame; honoured only in IDLE
in_valid  in  1  pixel valid
in_ready  out  1  pixel accepted when in_valid && in_ready
in_red  in  8  red; gray value when CHANNELS=1
in_green  in  8  green; ignored when CHANNELS=1
in_blue  in  8  blue; ignored when CHANNELS=1
out_data  out  8  file byte
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts a byte when out_valid && out_ready
out_last  out  1  high with the final byte of the file
busy  out  1  high from start acceptance to done
done  out  1  one-cycle pulse after the last byte is accepted
frame_count  out  16  frames completed, wraps at 0xFFFF

Behaviour:
- Derived values: ROW_BYTES = ceil(WIDTH*CHANNELS/4)*4; PAD = ROW_BYTES - WIDTH*CHANNELS; HDR = 54 + (CHANNELS==1 ? 1024 : 0); IMG = ROW_BYTES*HEIGHT; FILE = HDR+IMG. All 32-bit header fields are little-endian.
- Header bytes, in order:
  - "BM", FILE, 0 (4 bytes), HDR (offset), 40, WIDTH, -HEIGHT (32-bit two's complement).
  - planes=1 (16-bit), bitcount=8*CHANNELS (16-bit), compression 0, IMG, PPM, PPM.
  - clrUsed = 256 if CHANNELS=1 else 0; clrImportant 0.
- Palette (CHANNELS=1 only): entry k = bytes k,k,k,0 for k=0..255.
- Reset values: out_valid=0, out_data=0, out_last=0, in_ready=0, busy=0, done=0, frame_count=0. State = IDLE.
- States:
  - IDLE: start -> HEADER, busy=1.
  - HEADER: emits byte index 0..53, then goes to PALETTE if CHANNELS=1, else PIX_LOAD.
  - PALETTE: emits 1024 bytes, then PIX_LOAD.
  - PIX_LOAD: in_ready=1 and out_valid=0. On accept, latch the pixel and go to PIX_EMIT.
  - PIX_EMIT: emits B,G,R (or the single gray byte). After the final channel: go to PAD if end of row and PAD>0; otherwise PIX_LOAD. After the last pixel of the frame with PAD=0, go to FIN.
  - PAD: emits PAD zero bytes, then PIX_LOAD, or FIN after the last row.
  - FIN: done=1 for one cycle, frame_count+1, busy=0, then IDLE.
- Output handshake:
  - out_data and out_valid are registered.
  - Once out_valid=1, out_data and out_last hold until out_ready=1.
  - One byte per cycle maximum.
  - out_valid=1 with out_ready=0 stalls all counters.
- out_last is asserted on the last byte of the file: the last pad byte, or the last pixel byte if PAD=0.
- Counters: col and row count pixels and wrap at WIDTH-1 and HEIGHT-1; the byte index covers up to HDR-1; the channel index runs 0..CHANNELS-1.
- start outside IDLE is ignored. start and done in the same cycle: start is ignored.
- Reset mid-frame: immediately returns to IDLE with reset values. The partial file is abandoned and frame_count is cleared.
- Latency: start -> first out_valid = 1 cycle. Pixel accept -> first pixel byte valid = 1 cycle.

Test Plan:
- WIDTH=3, HEIGHT=2, CHANNELS=3, out_ready=1, pixels 0x102030 step +1 -> 78 bytes total.
  - Bytes 2..5 = 4E 00 00 00; bytes 10..13 = 36 00 00 00; bytes 22..25 = FE FF FF FF; bytes 28..29 = 18 00; bytes 34..37 = 18 00 00 00.
  - Bytes 54..56 = 30 20 10; bytes 63..65 = 00 00 00 (row pad); out_last on byte 77; done one cycle later; frame_count=1.
- WIDTH=5, HEIGHT=1, CHANNELS=1 -> 1086 bytes.
  - Bytes 2..5 = 3E 04 00 00; bytes 10..13 = 36 04 00 00; bytes 46..49 = 00 01 00 00.
  - Palette bytes 82..85 = 07 07 07 00; gray pixels at bytes 1078..1082 followed by 3 zero pad bytes.
- WIDTH=4, HEIGHT=2, CHANNELS=3 (PAD=0) -> 78 bytes, no pad bytes; out_last on the final R byte.
- Random out_ready (50% duty) and random in_valid gaps -> byte stream identical to the no-stall run. out_data is stable while out_valid && !out_ready.
- reset pulse at header byte 20 and again mid-row, then a new start -> stream restarts at 42 4D; frame_count=0 before restart. start pulsed while busy -> no effect.
- Three back-to-back frames, with start asserted on the cycle after done -> frame_count=3; each file is byte-identical.

Source files
------------

// File: rtl/bmp_stream_writer.sv
`default_nettype none
// ============================================================================
//  Module   : bmp_stream_writer
//  Brief    : Converts a raster-order RGB/gray pixel stream into a complete
//             top-down BMP file on a valid/ready byte port. Header, optional
//             gray palette and 4-byte row padding are generated on the fly.
//  Revision : 1.0 - initial release
// ============================================================================
module bmp_stream_writer #(
   parameter int WIDTH    = 256,
   parameter int HEIGHT   = 256,
   parameter int CHANNELS = 3,
   parameter int PPM      = 2835
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_red,
   input  logic [7:0]  in_green,
   input  logic [7:0]  in_blue,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last,
   output logic        busy,
   output logic        done,
   output logic [15:0] frame_count
);

   // Derived file geometry
   localparam int c_row_bytes = ((WIDTH * CHANNELS + 3) / 4) * 4;
   localparam int c_pad       = c_row_bytes - WIDTH * CHANNELS;
   localparam int c_hdr_bytes = 54 + ((CHANNELS == 1) ? 1024 : 0);
   localparam int c_img_bytes = c_row_bytes * HEIGHT;
   localparam int c_file_bytes = c_hdr_bytes + c_img_bytes;
   localparam int c_clr_used  = (CHANNELS == 1) ? 256 : 0;

   localparam logic [31:0] c_neg_height = 32'd0 - 32'(HEIGHT);
   localparam logic [11:0] c_last_col   = 12'(WIDTH - 1);
   localparam logic [11:0] c_last_row   = 12'(HEIGHT - 1);
   localparam logic [1:0]  c_last_chan  = 2'(CHANNELS - 1);
   localparam logic [1:0]  c_last_pad   = 2'(c_pad - 1);

   // Header image with byte 0 in bits [7:0]; fields listed last-to-first so
   // every multi-byte field lands little-endian without byte swapping.
   localparam logic [431:0] c_hdr_image = {
      32'd0, 32'(c_clr_used), 32'(PPM), 32'(PPM), 32'(c_img_bytes), 32'd0,
      16'(8 * CHANNELS), 16'd1, c_neg_height, 32'(WIDTH), 32'd40,
      32'(c_hdr_bytes), 32'd0, 32'(c_file_bytes), 8'h4D, 8'h42
   };

   typedef enum logic [2:0] {
      S_IDLE, S_HEADER, S_PALETTE, S_PIX_LOAD, S_PIX_EMIT, S_PAD, S_FIN
   } state_t;

   state_t      state_q, state_d;
   logic [5:0]  idx_q, idx_d;
   logic [9:0]  pidx_q, pidx_d;
   logic [11:0] col_q, col_d;
   logic [11:0] row_q, row_d;
   logic [1:0]  chan_q, chan_d;
   logic [1:0]  pad_q, pad_d;
   logic [7:0]  pix_r_q, pix_r_d;
   logic [7:0]  pix_g_q, pix_g_d;
   logic [7:0]  pix_b_q, pix_b_d;
   logic [7:0]  out_data_q, out_data_d;
   logic        out_valid_q, out_valid_d;
   logic        out_last_q, out_last_d;
   logic [15:0] frame_count_q, frame_count_d;

   logic [5:0]  w_idx_next;
   logic [9:0]  w_pidx_next;
   logic [7:0]  w_hdr_next;
   logic [7:0]  w_pal_next;
   logic [11:0] w_row_next;
   logic        w_last_pix;

   assign w_idx_next  = (idx_q == 6'd53) ? 6'd0 : idx_q + 6'd1;
   assign w_hdr_next  = c_hdr_image[{w_idx_next, 3'b000} +: 8];
   assign w_pidx_next = pidx_q + 10'd1;
   // Palette entry k is k,k,k,0
   assign w_pal_next  = (w_pidx_next[1:0] == 2'd3) ? 8'h00 : w_pidx_next[9:2];
   assign w_row_next  = (row_q == c_last_row) ? 12'd0 : row_q + 12'd1;
   assign w_last_pix  = (col_q == c_last_col) && (row_q == c_last_row);

   assign in_ready    = (state_q == S_PIX_LOAD);
   assign busy        = (state_q != S_IDLE) && (state_q != S_FIN);
   assign done        = (state_q == S_FIN);
   assign out_data    = out_data_q;
   assign out_valid   = out_valid_q;
   assign out_last    = out_last_q;
   assign frame_count = frame_count_q;

   // Next-state and next-byte selection; every advance is gated by the
   // downstream accepting the byte currently held in the output register.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      pidx_d        = pidx_q;
      col_d         = col_q;
      row_d         = row_q;
      chan_d        = chan_q;
      pad_d         = pad_q;
      pix_r_d       = pix_r_q;
      pix_g_d       = pix_g_q;
      pix_b_d       = pix_b_q;
      out_data_d    = out_data_q;
      out_valid_d   = out_valid_q;
      out_last_d    = out_last_q;
      frame_count_d = frame_count_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_HEADER;
               idx_d       = 6'd0;
               col_d       = 12'd0;
               row_d       = 12'd0;
               out_data_d  = 8'h42;
               out_valid_d = 1'b1;
               out_last_d  = 1'b0;
            end
         end
         S_HEADER: begin
            if (out_ready) begin
               if (idx_q == 6'd53) begin
                  if (CHANNELS == 1) begin
                     state_d    = S_PALETTE;
                     pidx_d     = 10'd0;
                     out_data_d = 8'h00;
                  end else begin
                     state_d     = S_PIX_LOAD;
                     out_valid_d = 1'b0;
                  end
               end else begin
                  idx_d      = w_idx_next;
                  out_data_d = w_hdr_next;
               end
            end
         end
         S_PALETTE: begin
            if (out_ready) begin
               if (pidx_q == 10'd1023) begin
                  state_d     = S_PIX_LOAD;
                  out_valid_d = 1'b0;
               end else begin
                  pidx_d     = w_pidx_next;
                  out_data_d = w_pal_next;
               end
            end
         end
         S_PIX_LOAD: begin
            if (in_valid) begin
               pix_r_d     = in_red;
               pix_g_d     = in_green;
               pix_b_d     = in_blue;
               chan_d      = 2'd0;
               out_valid_d = 1'b1;
               out_data_d  = (CHANNELS == 1) ? in_red : in_blue;
               out_last_d  = w_last_pix && (c_pad == 0) && (CHANNELS == 1);
               state_d     = S_PIX_EMIT;
            end
         end
         S_PIX_EMIT: begin
            if (out_ready) begin
               if (chan_q == c_last_chan) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  state_d     = S_PIX_LOAD;
                  if (col_q == c_last_col) begin
                     if (c_pad != 0) begin
                        // Row position advances once the padding is out
                        state_d     = S_PAD;
                        pad_d       = 2'd0;
                        out_valid_d = 1'b1;
                        out_data_d  = 8'h00;
                        out_last_d  = (row_q == c_last_row) && (c_pad == 1);
                     end else begin
                        col_d = 12'd0;
                        row_d = w_row_next;
                        if (row_q == c_last_row) begin
                           state_d = S_FIN;
                        end
                     end
                  end else begin
                     col_d = col_q + 12'd1;
                  end
               end else begin
                  chan_d     = chan_q + 2'd1;
                  out_data_d = (chan_q == 2'd0) ? pix_g_q : pix_r_q;
                  out_last_d = w_last_pix && (c_pad == 0) &&
                               (chan_q + 2'd1 == c_last_chan);
               end
            end
         end
         S_PAD: begin
            if (out_ready) begin
               if (pad_q == c_last_pad) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  col_d       = 12'd0;
                  row_d       = w_row_next;
                  state_d     = (row_q == c_last_row) ? S_FIN : S_PIX_LOAD;
               end else begin
                  pad_d      = pad_q + 2'd1;
                  out_data_d = 8'h00;
                  out_last_d = (row_q == c_last_row) &&
                               (pad_q + 2'd1 == c_last_pad);
               end
            end
         end
         S_FIN: begin
            frame_count_d = frame_count_q + 16'd1;
            state_d       = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, counters, pixel latch and output register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         idx_q         <= 6'd0;
         pidx_q        <= 10'd0;
         col_q         <= 12'd0;
         row_q         <= 12'd0;
         chan_q        <= 2'd0;
         pad_q         <= 2'd0;
         pix_r_q       <= 8'd0;
         pix_g_q       <= 8'd0;
         pix_b_q       <= 8'd0;
         out_data_q    <= 8'd0;
         out_valid_q   <= 1'b0;
         out_last_q    <= 1'b0;
         frame_count_q <= 16'd0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         pidx_q        <= pidx_d;
         col_q         <= col_d;
         row_q         <= row_d;
         chan_q        <= chan_d;
         pad_q         <= pad_d;
         pix_r_q       <= pix_r_d;
         pix_g_q       <= pix_g_d;
         pix_b_q       <= pix_b_d;
         out_data_q    <= out_data_d;
         out_valid_q   <= out_valid_d;
         out_last_q    <= out_last_d;
         frame_count_q <= frame_count_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bmp_stream_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bmp_stream_writer
//  Brief    : Self-checking bench for bmp_stream_writer; three instances
//             (3x2 RGB with pad, 5x1 gray with palette, 4x2 RGB no pad)
//             checked against a file-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bmp_stream_writer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start [3];
   logic        in_valid [3];
   logic        in_ready [3];
   logic [7:0]  in_red [3];
   logic [7:0]  in_green [3];
   logic [7:0]  in_blue [3];
   logic [7:0]  out_data [3];
   logic        out_valid [3];
   logic        out_ready [3];
   logic        out_last [3];
   logic        busy [3];
   logic        done [3];
   logic [15:0] frame_count [3];

   int checks = 0;
   int errors = 0;
   int exp_fc [3];
   int last_idx;

   logic [23:0] pix_q [$];
   logic [7:0]  exp_q [$];
   logic [7:0]  got_q [$];
   logic [7:0]  ref_q [$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      bmp_stream_writer #(
         .WIDTH    ((g == 0) ? 3 : ((g == 1) ? 5 : 4)),
         .HEIGHT   ((g == 1) ? 1 : 2),
         .CHANNELS ((g == 1) ? 1 : 3),
         .PPM      (2835)
      ) u_dut (
         .clk         (clk),
         .reset       (reset),
         .start       (start[g]),
         .in_valid    (in_valid[g]),
         .in_ready    (in_ready[g]),
         .in_red      (in_red[g]),
         .in_green    (in_green[g]),
         .in_blue     (in_blue[g]),
         .out_data    (out_data[g]),
         .out_valid   (out_valid[g]),
         .out_ready   (out_ready[g]),
         .out_last    (out_last[g]),
         .busy        (busy[g]),
         .done        (done[g]),
         .frame_count (frame_count[g])
      );
   end

   function automatic int wd(input int d);
      return (d == 0) ? 3 : ((d == 1) ? 5 : 4);
   endfunction
   function automatic int ht(input int d);
      return (d == 1) ? 1 : 2;
   endfunction
   function automatic int ch(input int d);
      return (d == 1) ? 1 : 3;
   endfunction

   task automatic put32(input logic [31:0] v);
      for (int i = 0; i < 4; i++) exp_q.push_back(v[8*i +: 8]);
   endtask

   // Reference model: whole BMP file from geometry and the pixel list
   task automatic build_exp(input int d);
      int w, h, c, rb, pad, hdr, img;
      logic [23:0] p;
      w = wd(d); h = ht(d); c = ch(d);
      rb  = ((w * c + 3) / 4) * 4;
      pad = rb - w * c;
      hdr = 54 + ((c == 1) ? 1024 : 0);
      img = rb * h;
      exp_q.delete();
      exp_q.push_back(8'h42);
      exp_q.push_back(8'h4D);
      put32(32'(hdr + img)); put32(0); put32(32'(hdr)); put32(40);
      put32(32'(w)); put32(32'(-h));
      exp_q.push_back(8'd1); exp_q.push_back(8'd0);
      exp_q.push_back(8'(8 * c)); exp_q.push_back(8'd0);
      put32(0); put32(32'(img)); put32(2835); put32(2835);
      put32((c == 1) ? 32'd256 : 32'd0); put32(0);
      if (c == 1)
         for (int k = 0; k < 256; k++) begin
            exp_q.push_back(8'(k)); exp_q.push_back(8'(k));
            exp_q.push_back(8'(k)); exp_q.push_back(8'd0);
         end
      for (int r = 0; r < h; r++) begin
         for (int x = 0; x < w; x++) begin
            p = pix_q[r * w + x];
            if (c == 3) begin
               exp_q.push_back(p[7:0]); exp_q.push_back(p[15:8]);
               exp_q.push_back(p[23:16]);
            end else begin
               exp_q.push_back(p[23:16]);
            end
         end
         for (int k = 0; k < pad; k++) exp_q.push_back(8'd0);
      end
   endtask

   task automatic fill_pixels(input int d, input bit rnd);
      pix_q.delete();
      for (int k = 0; k < wd(d) * ht(d); k++)
         pix_q.push_back(rnd ? 24'($urandom) : 24'h102030 + 24'(k));
   endtask

   // Drives one frame on instance d from a negedge; returns at a negedge.
   // abort_at >= 0 stops once that many bytes have been accepted.
   task automatic run_frame(input int d, input bit stall, input bit gaps,
                            input bit poke, input int abort_at);
      int pi, cyc, n, mism;
      bit fin, exp_done, prev_stall, acc_prev, xfer, acc;
      logic [7:0] prev_data;
      logic prev_last;
      logic [23:0] pv;
      n = pix_q.size();
      got_q.delete();
      last_idx = -1; pi = 0; cyc = 0; fin = 0; exp_done = 0;
      prev_stall = 0; acc_prev = 0; prev_data = 0; prev_last = 0;
      start[d] = 1'b1;
      @(posedge clk); @(negedge clk);
      start[d] = 1'b0;
      checks++;
      if (out_valid[d] !== 1'b1 || busy[d] !== 1'b1 || out_data[d] !== 8'h42) begin
         errors++;
         $display("FAIL start_latency dut%0d: out_valid=%b busy=%b data=%h, required 1 1 42",
                  d, out_valid[d], busy[d], out_data[d]);
      end
      while (!fin) begin
         if (abort_at >= 0 && got_q.size() >= abort_at) begin
            in_valid[d] = 1'b0; out_ready[d] = 1'b0; start[d] = 1'b0;
            return;
         end
         if (cyc >= 20000) begin
            checks++; errors++;
            $display("FAIL timeout dut%0d: %0d bytes after %0d cycles, required %0d bytes",
                     d, got_q.size(), cyc, exp_q.size());
            in_valid[d] = 1'b0; out_ready[d] = 1'b0; start[d] = 1'b0;
            return;
         end
         if (exp_done) begin
            checks++;
            if (done[d] !== 1'b1 || busy[d] !== 1'b0) begin
               errors++;
               $display("FAIL done_pulse dut%0d: done=%b busy=%b, required 1 0",
                        d, done[d], busy[d]);
            end
            fin = 1;
            start[d] = poke;   // coincides with done: must be ignored
            in_valid[d] = 1'b0;
            @(posedge clk); @(negedge clk);
            start[d] = 1'b0;
            checks++;
            if (busy[d] !== 1'b0 || out_valid[d] !== 1'b0 || done[d] !== 1'b0) begin
               errors++;
               $display("FAIL idle_after_done dut%0d: busy=%b out_valid=%b done=%b, required 0 0 0",
                        d, busy[d], out_valid[d], done[d]);
            end
         end else begin
            checks++;
            if (done[d] !== 1'b0 || (in_ready[d] === 1'b1 && out_valid[d] === 1'b1)) begin
               errors++;
               $display("FAIL early_done_or_overlap dut%0d: done=%b in_ready=%b out_valid=%b, required done 0 and not both",
                        d, done[d], in_ready[d], out_valid[d]);
            end
            if (prev_stall) begin
               checks++;
               if (out_valid[d] !== 1'b1 || out_data[d] !== prev_data || out_last[d] !== prev_last) begin
                  errors++;
                  $display("FAIL hold dut%0d: valid=%b data=%h last=%b, required 1 %h %b",
                           d, out_valid[d], out_data[d], out_last[d], prev_data, prev_last);
               end
            end
            if (acc_prev) begin
               checks++;
               if (out_valid[d] !== 1'b1) begin
                  errors++;
                  $display("FAIL accept_latency dut%0d: out_valid=%b, required 1", d, out_valid[d]);
               end
            end
            start[d]     = poke && ($urandom_range(7, 0) == 0);
            in_valid[d]  = (pi < n) && (!gaps || $urandom_range(1, 0) == 1);
            pv           = (pi < n) ? pix_q[pi] : 24'($urandom);
            in_red[d]    = pv[23:16];
            in_green[d]  = pv[15:8];
            in_blue[d]   = pv[7:0];
            out_ready[d] = !stall || ($urandom_range(1, 0) == 1);
            xfer = (out_valid[d] === 1'b1) && out_ready[d];
            acc  = in_valid[d] && (in_ready[d] === 1'b1);
            if (xfer) begin
               got_q.push_back(out_data[d]);
               if (out_last[d] === 1'b1) begin
                  last_idx = got_q.size() - 1;
                  exp_done = 1;
               end
            end
            if (acc) pi++;
            prev_stall = (out_valid[d] === 1'b1) && !out_ready[d];
            prev_data  = out_data[d];
            prev_last  = out_last[d];
            acc_prev   = acc;
            @(posedge clk); @(negedge clk);
            cyc++;
         end
      end
      out_ready[d] = 1'b0;
      exp_fc[d]++;
      mism = -1;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         if (mism < 0 && got_q[i] !== exp_q[i]) mism = i;
      checks++;
      if (mism >= 0 || got_q.size() != exp_q.size()) begin
         errors++;
         if (mism >= 0)
            $display("FAIL stream dut%0d: byte %0d = %h, required %h (got %0d bytes, required %0d)",
                     d, mism, got_q[mism], exp_q[mism], got_q.size(), exp_q.size());
         else
            $display("FAIL stream dut%0d: got %0d bytes, required %0d", d, got_q.size(), exp_q.size());
      end
      checks++;
      if (last_idx != exp_q.size() - 1) begin
         errors++;
         $display("FAIL out_last_pos dut%0d: at byte %0d, required %0d", d, last_idx, exp_q.size() - 1);
      end
      checks++;
      if (frame_count[d] !== 16'(exp_fc[d])) begin
         errors++;
         $display("FAIL frame_count dut%0d: %0d, required %0d", d, frame_count[d], exp_fc[d]);
      end
   endtask

   task automatic test_reset;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if ({out_valid[d], out_data[d], out_last[d], in_ready[d], busy[d], done[d], frame_count[d]} !== 29'd0) begin
            errors++;
            $display("FAIL reset_values dut%0d: valid=%b data=%h last=%b in_ready=%b busy=%b done=%b fc=%0d, required all 0",
                     d, out_valid[d], out_data[d], out_last[d], in_ready[d], busy[d], done[d], frame_count[d]);
         end
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy[0] !== 1'b0 || out_valid[0] !== 1'b0 || in_ready[0] !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: busy=%b out_valid=%b in_ready=%b, required 0 0 0",
                  busy[0], out_valid[0], in_ready[0]);
      end
   endtask

   task automatic test_rgb_pad;
      int          ci [24] = '{2, 3, 4, 5, 10, 11, 12, 13, 22, 23, 24, 25, 28, 29,
                               34, 35, 36, 37, 54, 55, 56, 63, 64, 65};
      logic [7:0]  cv [24] = '{8'h4E, 8'h00, 8'h00, 8'h00, 8'h36, 8'h00, 8'h00, 8'h00,
                               8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'h18, 8'h00,
                               8'h18, 8'h00, 8'h00, 8'h00, 8'h30, 8'h20, 8'h10,
                               8'h00, 8'h00, 8'h00};
      fill_pixels(0, 0);
      build_exp(0);
      run_frame(0, 0, 0, 0, -1);
      for (int k = 0; k < 24; k++) begin
         checks++;
         if (got_q.size() <= ci[k] || got_q[ci[k]] !== cv[k]) begin
            errors++;
            $display("FAIL rgb_byte[%0d]: %h, required %h", ci[k],
                     (got_q.size() > ci[k]) ? got_q[ci[k]] : 8'hxx, cv[k]);
         end
      end
      checks++;
      if (got_q.size() != 78 || last_idx != 77 || frame_count[0] !== 16'd1) begin
         errors++;
         $display("FAIL rgb_size: %0d bytes last@%0d fc=%0d, required 78 77 1",
                  got_q.size(), last_idx, frame_count[0]);
      end
   endtask

   task automatic test_gray_palette;
      int          ci [19] = '{2, 3, 4, 5, 10, 11, 12, 13, 46, 47, 48, 49,
                               82, 83, 84, 85, 1083, 1084, 1085};
      logic [7:0]  cv [19] = '{8'h3E, 8'h04, 8'h00, 8'h00, 8'h36, 8'h04, 8'h00, 8'h00,
                               8'h00, 8'h01, 8'h00, 8'h00, 8'h07, 8'h07, 8'h07, 8'h00,
                               8'h00, 8'h00, 8'h00};
      fill_pixels(1, 1);
      build_exp(1);
      run_frame(1, 0, 0, 0, -1);
      for (int k = 0; k < 19; k++) begin
         checks++;
         if (got_q.size() <= ci[k] || got_q[ci[k]] !== cv[k]) begin
            errors++;
            $display("FAIL gray_byte[%0d]: %h, required %h", ci[k],
                     (got_q.size() > ci[k]) ? got_q[ci[k]] : 8'hxx, cv[k]);
         end
      end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (got_q.size() <= 1078 + k || got_q[1078 + k] !== pix_q[k][23:16]) begin
            errors++;
            $display("FAIL gray_pixel[%0d]: %h, required %h", k,
                     (got_q.size() > 1078 + k) ? got_q[1078 + k] : 8'hxx, pix_q[k][23:16]);
         end
      end
      checks++;
      if (got_q.size() != 1086) begin
         errors++;
         $display("FAIL gray_size: %0d bytes, required 1086", got_q.size());
      end
   endtask

   task automatic test_no_pad;
      fill_pixels(2, 1);
      build_exp(2);
      run_frame(2, 0, 0, 0, -1);
      checks++;
      if (got_q.size() != 78 || last_idx != 77 || got_q[77] !== pix_q[7][23:16] ||
          got_q[66] !== pix_q[4][7:0]) begin
         errors++;
         $display("FAIL nopad: %0d bytes last@%0d b77=%h b66=%h, required 78 77 %h %h",
                  got_q.size(), last_idx, got_q[77], got_q[66], pix_q[7][23:16], pix_q[4][7:0]);
      end
   endtask

   task automatic test_stall_gaps;
      for (int d = 0; d < 3; d++) begin
         fill_pixels(d, 1);
         build_exp(d);
         run_frame(d, 1, 1, 0, -1);
      end
   endtask

   task automatic test_start_while_busy;
      fill_pixels(1, 1);
      build_exp(1);
      run_frame(1, 1, 1, 1, -1);
      fill_pixels(0, 1);
      build_exp(0);
      run_frame(0, 1, 0, 1, -1);
   endtask

   task automatic test_reset_mid;
      int cut [2] = '{20, 59};
      for (int k = 0; k < 2; k++) begin
         fill_pixels(0, 1);
         build_exp(0);
         run_frame(0, k == 1, k == 1, 0, cut[k]);
         reset = 1'b1;
         #1;
         checks++;
         if ({out_valid[0], out_data[0], out_last[0], in_ready[0], busy[0], done[0], frame_count[0]} !== 29'd0) begin
            errors++;
            $display("FAIL reset_mid[%0d]: valid=%b data=%h last=%b in_ready=%b busy=%b fc=%0d, required all 0",
                     k, out_valid[0], out_data[0], out_last[0], in_ready[0], busy[0], frame_count[0]);
         end
         for (int d = 0; d < 3; d++) exp_fc[d] = 0;
         @(negedge clk);
         reset = 1'b0;
         @(negedge clk);
      end
      fill_pixels(0, 1);
      build_exp(0);
      run_frame(0, 1, 1, 0, -1);
      checks++;
      if (got_q.size() < 2 || got_q[0] !== 8'h42 || got_q[1] !== 8'h4D || frame_count[0] !== 16'd1) begin
         errors++;
         $display("FAIL restart: first=%h %h fc=%0d, required 42 4D 1", got_q[0], got_q[1], frame_count[0]);
      end
   endtask

   task automatic test_back_to_back;
      fill_pixels(2, 1);
      build_exp(2);
      for (int f = 0; f < 3; f++) begin
         run_frame(2, f == 1, f == 2, 1, -1);
         if (f == 0) begin
            ref_q = got_q;
         end else begin
            checks++;
            if (got_q != ref_q) begin
               errors++;
               $display("FAIL b2b_identical frame%0d: %0d bytes, required %0d identical bytes",
                        f, got_q.size(), ref_q.size());
            end
         end
      end
      checks++;
      if (frame_count[2] !== 16'd3) begin
         errors++;
         $display("FAIL b2b_count: %0d, required 3", frame_count[2]);
      end
   endtask

   initial begin
      reset = 1'b1;
      for (int d = 0; d < 3; d++) begin
         start[d] = 1'b0; in_valid[d] = 1'b0; out_ready[d] = 1'b0;
         in_red[d] = 8'd0; in_green[d] = 8'd0; in_blue[d] = 8'd0;
         exp_fc[d] = 0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      test_reset;
      test_rgb_pad;
      test_gray_palette;
      test_no_pad;
      test_stall_gaps;
      test_start_while_busy;
      test_reset_mid;
      test_back_to_back;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #(900_000);
      $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
